// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the byte PC, issues 1-cycle-latency reads to the
// 16-bit instruction memory, buffers returns in a small circular fetch queue and
// presents {pc, instr} to decode over valid/ready. Handles branch redirects and
// HALT-word detection (RUN -> DRAIN -> HALTED).
// Optional feature: define FETCH_STALL_CNT_EN to build the saturating
// backpressure counter on stall_count; otherwise stall_count is tied to zero.
module instruction_fetch_unit #(
  parameter logic [7:0]  RESET_PC  = 8'h00,
  parameter int          FQ_DEPTH  = 2,
  parameter logic [15:0] HALT_WORD = 16'h0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_rd_en,
  output logic [7:0]  imem_addr,
  input  logic [15:0] imem_data,
  input  logic        redirect_valid,
  input  logic [7:0]  redirect_pc,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [15:0] if_instr,
  output logic [7:0]  if_pc,
  output logic        halted,
  output logic [15:0] stall_count
);

  localparam int         PW    = (FQ_DEPTH > 2) ? 2 : 1;
  localparam logic [2:0] DEPTH = 3'(FQ_DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } fq_entry_t;

  state_t          state, state_nxt;
  logic [7:0]      pc, ret_pc;
  logic            inflight;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [2:0]      count, occ;
  fq_entry_t       fq [FQ_DEPTH];
  fq_entry_t       head;
  logic            deq, enq, issue, halt_ret, flush;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FQ_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Handshake, enqueue and issue decisions for this cycle
  always_comb begin
    head       = fq[rd_ptr];
    flush      = redirect_valid && (state != HALTED);
    if_valid   = (count != 3'd0) && (state != HALTED);
    if_instr   = if_valid ? head.instr : 16'h0000;
    if_pc      = if_valid ? head.pc    : 8'h00;
    // a dequeue coinciding with a redirect is dropped along with the queue
    deq        = if_valid && if_ready && !flush;
    enq        = inflight && !flush;
    halt_ret   = inflight && (imem_data == HALT_WORD);
    occ        = count + {2'b0, inflight} - {2'b0, deq};
    // the cycle a HALT word returns must not issue anything past it
    issue      = !reset && (state == RUN) && !redirect_valid && !halt_ret && (occ < DEPTH);
    imem_rd_en = issue;
    imem_addr  = pc;
  end

  // Next-state logic for the halt handling FSM
  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (!redirect_valid && halt_ret) state_nxt = DRAIN;
      DRAIN:   if (redirect_valid) state_nxt = RUN;
               else if (deq && head.instr == HALT_WORD) state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  // State register and the sticky halted flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= RUN;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= (state_nxt == HALTED);
    end
  end

  // PC, in-flight tracking and queue pointers; a redirect flushes everything
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc       <= RESET_PC & 8'hFE;
      ret_pc   <= 8'h00;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 3'd0;
    end else if (flush) begin
      pc       <= redirect_pc & 8'hFE;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= 3'd0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + 8'd2;
        ret_pc <= pc;
      end
      if (enq) wr_ptr <= ptr_inc(wr_ptr);
      if (deq) rd_ptr <= ptr_inc(rd_ptr);
      count <= count + {2'b0, enq} - {2'b0, deq};
    end
  end

  // Queue storage; contents are qualified by count so no reset is needed
  always_ff @(posedge clk) begin
    if (enq) fq[wr_ptr] <= '{pc: ret_pc, instr: imem_data};
  end

`ifdef FETCH_STALL_CNT_EN
  // Saturating count of cycles where decode holds off a valid head
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      stall_count <= 16'h0000;
    else if (if_valid && !if_ready && stall_count != 16'hFFFF)
      stall_count <= stall_count + 16'd1;
  end
`else
  assign stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: memory model, scoreboard of
// expected {pc, instr} pairs, directed reset/stall/redirect/halt scenarios and
// a second instance built with RESET_PC = 8'hFC for the wrap case.
module tb_instruction_fetch_unit;

  typedef struct packed {
    logic [7:0]  pc;
    logic [15:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, if_ready;
  logic [7:0]  redirect_pc;
  logic [15:0] imem_data = 16'h0;
  logic        imem_rd_en, if_valid, halted;
  logic [7:0]  imem_addr, if_pc;
  logic [15:0] if_instr, stall_count;

  logic        reset2, ready2;
  logic        redir2 = 1'b0;
  logic [7:0]  rpc2 = 8'h00;
  logic [15:0] imem_data2 = 16'h0;
  logic        rd_en2, valid2, halted2;
  logic [7:0]  addr2, pc2;
  logic [15:0] instr2, stall2;

  logic [15:0] mem [128];
  exp_t        exp_q [$];
  int          checks = 0, errors = 0;
  logic        halt_nxt = 1'b0, t4_mon = 1'b0;
  logic [7:0]  max_addr = 8'h00;
  int          n_iss = 0;

`ifdef FETCH_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd5;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .imem_rd_en(imem_rd_en), .imem_addr(imem_addr),
    .imem_data(imem_data), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .halted(halted), .stall_count(stall_count)
  );

  instruction_fetch_unit #(.RESET_PC(8'hFC)) dut2 (
    .clk(clk), .reset(reset2), .imem_rd_en(rd_en2), .imem_addr(addr2),
    .imem_data(imem_data2), .redirect_valid(redir2), .redirect_pc(rpc2),
    .if_valid(valid2), .if_ready(ready2), .if_instr(instr2), .if_pc(pc2),
    .halted(halted2), .stall_count(stall2)
  );

  // 1-cycle read latency instruction memories
  always @(posedge clk) if (imem_rd_en) imem_data  <= mem[imem_addr[7:1]];
  always @(posedge clk) if (rd_en2)     imem_data2 <= mem[addr2[7:1]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push_stream(input logic [7:0] start, input int n);
    logic [7:0] p = start;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back('{pc: p, instr: mem[p[7:1]]});
      p = p + 8'd2;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard: every accepted head must match the next expected entry
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (halt_nxt) begin
        chk("halted_next", halted, 1);
        halt_nxt = 1'b0;
      end
      if (t4_mon && imem_rd_en) begin
        n_iss++;
        if (imem_addr > max_addr) max_addr = imem_addr;
      end
      if (if_valid && if_ready && !redirect_valid) begin
        if (exp_q.size() == 0) chk("sb_underflow", 32'(exp_q.size()), 1);
        else begin
          e = exp_q.pop_front();
          chk("sb_pc", if_pc, e.pc);
          chk("sb_instr", if_instr, e.instr);
          if (e.instr == 16'h0000) begin
            chk("halt_at_accept", halted, 0);
            halt_nxt = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 16'hA000 + 16'(i);
    mem[0] = 16'h21FE; mem[1] = 16'h22FB; mem[2] = 16'h5823;
    mem[8'h3E >> 1] = 16'h0000;
    mem[8'h60 >> 1] = 16'h0000;
    reset = 1'b1; if_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = 8'h00;
    reset2 = 1'b1; ready2 = 1'b1;
    tick(3);
    chk("rst_valid", if_valid, 0);
    chk("rst_rd_en", imem_rd_en, 0);
    chk("rst_halted", halted, 0);
    chk("rst_stall", stall_count, 0);
    chk("rst_pc", if_pc, 0);
    chk("rst_instr", if_instr, 0);

    // 1: streaming from reset, first valid in cycle 2
    push_stream(8'h00, 16);
    reset = 1'b0;
    @(negedge clk);
    chk("t1_c0_valid", if_valid, 0);
    chk("t1_c0_rd_en", imem_rd_en, 1);
    chk("t1_c0_addr", imem_addr, 8'h00);
    @(negedge clk); chk("t1_c1_valid", if_valid, 0);
    @(negedge clk); chk("t1_c2_valid", if_valid, 1);
    @(negedge clk); chk("t1_c3_valid", if_valid, 1);
    @(negedge clk); chk("t1_c4_valid", if_valid, 1);

    // 2: five cycles of backpressure with a full queue
    tick(1);
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t2_hold_pc", if_pc, 8'h06);
      chk("t2_hold_instr", if_instr, mem[3]);
      if (k == 4) chk("t2_rd_en_full", imem_rd_en, 0);
    end
    tick(1);
    if_ready = 1'b1;
    @(negedge clk); chk("t2_stall_count", stall_count, EXP_STALL);
    tick(4);

    // 3: redirect to 8'h41 with a full queue and a same-cycle ready
    if_ready = 1'b0;
    tick(3);
    redirect_valid = 1'b1; redirect_pc = 8'h41; if_ready = 1'b1;
    exp_q.delete(); push_stream(8'h40, 8);
    @(negedge clk); chk("t3_rd_en_redir", imem_rd_en, 0);
    tick(1);
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t3_flushed", if_valid, 0);
    chk("t3_addr", imem_addr, 8'h40);
    tick(5);

    // 5: HALT fetched at 8'h60, then wrong-path redirect to 8'h24
    if_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 8'h60;
    exp_q.delete();
    tick(1);
    redirect_valid = 1'b0;
    tick(4);
    @(negedge clk);
    chk("t5_head_pc", if_pc, 8'h60);
    chk("t5_head_instr", if_instr, 16'h0000);
    chk("t5_drain_rd_en", imem_rd_en, 0);
    tick(1);
    redirect_valid = 1'b1; redirect_pc = 8'h24;
    push_stream(8'h24, 6);
    tick(1);
    redirect_valid = 1'b0; if_ready = 1'b1;
    tick(6);
    chk("t5_not_halted", halted, 0);

    // 4: HALT at 8'h3E stops fetch; later redirect ignored
    redirect_valid = 1'b1; redirect_pc = 8'h38;
    exp_q.delete(); push_stream(8'h38, 4);
    max_addr = 8'h00; n_iss = 0; t4_mon = 1'b1;
    tick(1);
    redirect_valid = 1'b0;
    tick(12);
    t4_mon = 1'b0;
    chk("t4_max_addr", max_addr, 8'h3E);
    chk("t4_issues", n_iss, 4);
    chk("t4_halted", halted, 1);
    chk("t4_sb_drained", exp_q.size(), 0);
    redirect_valid = 1'b1; redirect_pc = 8'h10;
    tick(1);
    redirect_valid = 1'b0;
    tick(3);
    @(negedge clk);
    chk("t4_ign_valid", if_valid, 0);
    chk("t4_ign_rd_en", imem_rd_en, 0);
    chk("t4_ign_halted", halted, 1);

    // 6: async reset of the halted unit, then RESET_PC wrap on dut2
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_halted", halted, 0);
    chk("t6_rst_valid", if_valid, 0);
    chk("t6_rst_rd_en", imem_rd_en, 0);
    chk("t6_rst_pc", if_pc, 0);
    chk("t6_rst_stall", stall_count, 0);
    tick(1);
    reset2 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk); chk("t6_pc_fc", pc2, 8'hFC); chk("t6_in_fc", instr2, mem[126]);
    @(negedge clk); chk("t6_pc_fe", pc2, 8'hFE); chk("t6_in_fe", instr2, mem[127]);
    @(negedge clk); chk("t6_pc_00", pc2, 8'h00); chk("t6_in_00", instr2, 16'h21FE);
    #2 reset2 = 1'b1;
    #1;
    chk("t6_mid_valid", valid2, 0);
    chk("t6_mid_pc", pc2, 0);
    chk("t6_mid_instr", instr2, 0);
    chk("t6_mid_rd_en", rd_en2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
